// File: rtl/parity_serial_rx_if.sv
// Serial-link side and byte-consumer side of the parity receiver, bundled together.
// The master drives the strobe and the line; the slave is the receiver.
interface parity_serial_rx_if;
  logic       bit_en;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output bit_en, rx_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, rx_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_serial_rx.sv
// Framed serial receiver: start, 8 data bits LSB first, parity, stop.
// Delivers the byte with parity/framing status and a one-cycle valid pulse.
module parity_serial_rx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_serial_rx_if.slave   bus
);

  // state  | meaning
  // IDLE   | waiting for a start bit (rx_in=0 on a strobe)
  // DATA   | collecting d0..d7, LSB first
  // PARITY | comparing the parity bit against the running XOR
  // STOP   | sampling the stop bit and publishing the frame
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        bad_q, bad_d;
  logic [7:0]  data_q, data_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      bad_q   <= 1'b0;
      data_q  <= 8'h00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    bad_d   = bad_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.rx_in) begin
            state_d = DATA;
            cnt_d   = 3'd0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bus.rx_in;
          par_d          = par_q ^ bus.rx_in;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          bad_d   = ((par_q ^ bus.rx_in) != PARITY_ODD);
          state_d = STOP;
        end
        STOP: begin
          // Outputs update on the stop edge so they are stable while valid is high.
          data_d  = shift_q;
          perr_d  = bad_q;
          ferr_d  = ~bus.rx_in;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Drives one stream into an even-parity and an odd-parity receiver and checks
// both against a frame-level reference model.
module tb_parity_serial_rx;

  logic clk;
  logic rst_n;

  parity_serial_rx_if ife ();
  parity_serial_rx_if ifo ();

  parity_serial_rx #(.PARITY_ODD(1'b0)) u_even (.clk(clk), .rst_n(rst_n), .bus(ife.slave));
  parity_serial_rx #(.PARITY_ODD(1'b1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(ifo.slave));

  int n_cmp = 0;
  int n_err = 0;
  int pulses_e = 0;
  int pulses_o = 0;
  int exp_pulses = 0;
  logic [7:0] last_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ife.data_valid === 1'b1) pulses_e++;
    if (ifo.data_valid === 1'b1) pulses_o++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic b);
    ife.bit_en = en; ifo.bit_en = en;
    ife.rx_in  = b;  ifo.rx_in  = b;
  endtask

  task automatic send_bit(input logic b, input int gap);
    drive(1'b1, b);
    @(negedge clk);
    drive(1'b0, b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_e"}, ife.data_out, 0);
    check({tag, "_data_o"}, ifo.data_out, 0);
    check({tag, "_valid"}, {ife.data_valid, ifo.data_valid}, 0);
    check({tag, "_perr"}, {ife.parity_err, ifo.parity_err}, 0);
    check({tag, "_ferr"}, {ife.frame_err, ifo.frame_err}, 0);
    check({tag, "_busy"}, {ife.busy, ifo.busy}, 0);
  endtask

  // Model: byte delivered as-is; parity is bad when the count of ones across
  // data+parity bit has the wrong oddness; framing error when stop is 0.
  task automatic send_frame(input logic [7:0] b, input logic pb, input logic sb, input int gap);
    logic exp_pe, exp_po, exp_fe;
    int ones;
    ones   = $countones(b) + int'(pb);
    exp_pe = (ones % 2) != 0;
    exp_po = (ones % 2) != 1;
    exp_fe = ~sb;
    check("busy_idle", {ife.busy, ifo.busy}, 0);
    send_bit(1'b0, gap);
    check("busy_frame", {ife.busy, ifo.busy}, 2'b11);
    check("data_hold", {ife.data_out, ifo.data_out}, {last_data, last_data});
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    send_bit(pb, gap);
    check("valid_pre", {ife.data_valid, ifo.data_valid}, 0);
    drive(1'b1, sb);
    @(negedge clk);
    drive(1'b0, 1'b1);
    exp_pulses++;
    check("valid", {ife.data_valid, ifo.data_valid}, 2'b11);
    check("data_e", ife.data_out, b);
    check("data_o", ifo.data_out, b);
    check("perr_e", ife.parity_err, exp_pe);
    check("perr_o", ifo.parity_err, exp_po);
    check("ferr", {ife.frame_err, ifo.frame_err}, {exp_fe, exp_fe});
    check("busy_done", {ife.busy, ifo.busy}, 0);
    check("pulses_e", pulses_e, exp_pulses);
    check("pulses_o", pulses_o, exp_pulses);
    last_data = b;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rp, rs;
    int         rg;
    rst_n = 1'b0;
    drive(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("valid_clear", {ife.data_valid, ifo.data_valid}, 0);

    send_frame(8'h07, 1'b0, 1'b1, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1);

    send_frame(8'h3C, 1'b0, 1'b0, 0);

    // Reset in the middle of 0xFF after four data bits.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("pulses_rst", pulses_e + pulses_o, 2 * exp_pulses);
    send_frame(8'h5A, 1'b0, 1'b1, 0);

    for (int i = 0; i < 5; i++) send_bit(1'b1, 2);
    check("idle_busy", {ife.busy, ifo.busy}, 0);
    check("idle_pulses", pulses_e, exp_pulses);
    send_frame(8'h81, 1'b0, 1'b1, 2);

    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'h00, 1'b0, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rg = $urandom_range(0, 2);
      for (int k = $urandom_range(0, 2); k > 0; k--) send_bit(1'b1, rg);
      send_frame(rb, rp, rs, rg);
    end

    repeat (4) @(negedge clk);
    check("final_pulses_e", pulses_e, exp_pulses);
    check("final_pulses_o", pulses_o, exp_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Receive end of the team's 8-bit parity scheme: deserialises a framed bit stream (start, 8 data bits LSB first, parity bit, stop) and checks the parity bit against the data.
- Parity convention matches the team's 8-bit parity generator: even-parity bit = XOR of d0..d7.
- Sits between a serial link front end, which supplies a bit-rate strobe, and a byte consumer.

Parameters:
- PARITY_ODD, 0, 0 = even parity expected (XOR of d0..d7 and parity bit equals 0); 1 = odd parity expected (XOR equals 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_en  input  1  bit strobe; rx_in is sampled only on cycles where bit_en=1.
- rx_in  input  1  serial line; idles at 1.
- data_out  output  8  last received byte; d0 is bit 0.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch for the last completed frame.
- frame_err  output  1  stop bit of the last completed frame was 0.
- busy  output  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset (asynchronous on rst_n=0):
  - state=IDLE; bit counter=0; shift register=0; running parity=0.
  - data_out=8'h00; data_valid=0; parity_err=0; frame_err=0; busy=0.
  - Reset mid-frame discards the partial frame. No data_valid is produced for it.
- bit_en=0: all state holds and rx_in is ignored. The exception is data_valid, which always clears after one cycle.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - On bit_en with rx_in=0 (start bit): go to DATA, counter=0, running parity=0.
  - On bit_en with rx_in=1: stay in IDLE.
- DATA:
  - On each bit_en: shift register bit[counter] = rx_in; running parity ^= rx_in; counter++.
  - After the 8th data bit (counter was 7): go to PARITY. The counter wraps to 0.
- PARITY: on bit_en, capture parity_bad = (running parity ^ rx_in) != PARITY_ODD, then go to STOP.
- STOP: on bit_en, on the same edge:
  - data_out <= shift register.
  - parity_err <= parity_bad.
  - frame_err <= ~rx_in.
  - go to IDLE.
  - data_valid is asserted on the following cycle, for exactly one clock.
- Latency: data_valid is high in the clock cycle immediately after the cycle in which the stop bit is sampled. data_out, parity_err and frame_err are already stable in that cycle.
- Output hold: data_out, parity_err and frame_err hold until the next frame completes. They are not cleared at the next start bit.
- Frame error: the byte is still delivered with data_valid=1. Parity is still checked.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately after the stop bit. No idle bit is required.
- Simultaneous events: data_valid pulsing in the same cycle that a new start bit is sampled is legal. Both take effect.
- busy=1 from the edge that samples the start bit through the edge that samples the stop bit. It is 0 otherwise.
- No glitch filtering or oversampling. The front end guarantees one bit_en per bit, aligned mid-bit.

Test Plan:
1. Even-parity frame 0xA5 (PARITY_ODD=0): bits 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, with bit_en every cycle -> data_out=8'hA5, data_valid high for 1 cycle on the cycle after the stop sample, parity_err=0, frame_err=0, busy low afterwards.
2. Parity error: byte 0x07 with parity bit 0 -> data_out=8'h07, parity_err=1, frame_err=0. The following frame 0x07 with parity bit 1 -> parity_err=0.
3. Framing error: byte 0x3C, parity 0, stop bit 0 -> data_out=8'h3C, data_valid=1, frame_err=1, parity_err=0.
4. Idle and strobe gaps: rx_in=1 for 5 strobes, then frame 0x81 with bit_en pulsed every 3rd cycle -> no activity before the start bit, data_out=8'h81, exactly one data_valid pulse, no errors.
5. Reset mid-frame: assert rst_n=0 after 4 data bits of 0xFF -> all outputs 0 immediately (asynchronously), no data_valid. After release, a clean 0x5A frame -> data_out=8'h5A, no errors.
6. PARITY_ODD=1 with back-to-back frames: 0x01 with parity 0, then immediately 0x00 with parity 1 -> two data_valid pulses, data_out 8'h01 then 8'h00, parity_err=0 both times. Flipping the second frame's parity bit -> parity_err=1.
